// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned BURST_MAX  = 4;
    localparam int unsigned ACK_CNT_W  = 16;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first valid requester searching upward from i_last_gnt+1, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDW-1:0]     i_last_gnt,
    output logic [IDW-1:0]     o_pick,
    output logic               o_any
);

    int unsigned w_idx;

    always_comb begin
        o_pick = '0;
        o_any  = 1'b0;
        w_idx  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = (32'(i_last_gnt) + k) % NUM_REQ;
            if (!o_any && i_valid[w_idx]) begin
                o_any  = 1'b1;
                o_pick = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port from NUM_REQ requesters.
// Optional per-requester write-ack counters are enabled with macro FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = fifo_arb_pkg::NUM_REQ,
    parameter int unsigned FIFO_WIDTH = fifo_arb_pkg::FIFO_WIDTH,
    parameter int unsigned BURST_MAX  = fifo_arb_pkg::BURST_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic                          wr_en,
    input  logic                          full,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          busy,
    output logic                          ovf_err
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*ACK_CNT_W-1:0]  ack_cnt
`endif
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    arb_state_t     r_state, w_state_d;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_d;
    logic [IDW-1:0] r_last_gnt, w_last_gnt_d;
    logic [CW-1:0]  r_beat_cnt, w_beat_cnt_d;
    logic           r_ovf_err;

    logic [IDW-1:0] w_pick;
    logic           w_any;
    logic           w_gnt_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_valid    (req_valid),
        .i_last_gnt (r_last_gnt),
        .o_pick     (w_pick),
        .o_any      (w_any)
    );

    assign w_gnt_valid = req_valid[r_gnt_id];
    assign busy        = (r_state == ARB_BURST);
    assign wr_en       = busy & w_gnt_valid & ~full;
    assign gnt_id      = r_gnt_id;
    assign ovf_err     = r_ovf_err;
    assign data_in     = busy ? req_data[r_gnt_id*FIFO_WIDTH +: FIFO_WIDTH] : '0;

    always_comb begin
        req_ready = '0;
        if (wr_en) begin
            req_ready[r_gnt_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_gnt_id_d   = r_gnt_id;
        w_last_gnt_d = r_last_gnt;
        w_beat_cnt_d = r_beat_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_gnt_id_d   = w_pick;
                    w_last_gnt_d = w_pick;
                    w_beat_cnt_d = '0;
                    w_state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                // A dropped valid ends the burst; full with valid merely stalls it.
                if (!w_gnt_valid) begin
                    w_state_d    = ARB_IDLE;
                    w_beat_cnt_d = '0;
                end else if (wr_en) begin
                    if (r_beat_cnt == CW'(BURST_MAX - 1)) begin
                        w_state_d    = ARB_IDLE;
                        w_beat_cnt_d = '0;
                    end else begin
                        w_beat_cnt_d = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_gnt_id   <= '0;
            r_last_gnt <= IDW'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_gnt_id   <= w_gnt_id_d;
            r_last_gnt <= w_last_gnt_d;
            r_beat_cnt <= w_beat_cnt_d;
            r_ovf_err  <= r_ovf_err | overflow;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Acks arrive one cycle after the write, so credit the previously written requester.
    logic [IDW-1:0]       r_ack_owner;
    logic [ACK_CNT_W-1:0] r_ack_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_owner <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_ack_cnt[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_ack_owner <= r_gnt_id;
            end
            if (wr_ack && (r_ack_cnt[r_ack_owner] != {ACK_CNT_W{1'b1}})) begin
                r_ack_cnt[r_ack_owner] <= r_ack_cnt[r_ack_owner] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_ack_out
        assign ack_cnt[g*ACK_CNT_W +: ACK_CNT_W] = r_ack_cnt[g];
    end
`else
    logic w_unused_wr_ack;
    assign w_unused_wr_ack = wr_ack;
`endif

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter FIFO_WIDTH, default 16, data width of each requester and of the FIFO write port.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum consecutive accepted beats per grant (1..16).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*FIFO_WIDTH, packed requester data; slice i belongs to requester i.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester beat accepted this cycle.
REQ-009 SHALL have port data_in, output, FIFO_WIDTH, FIFO write data.
REQ-010 SHALL have port wr_en, output, 1, FIFO write enable.
REQ-011 SHALL have port full, input, 1, FIFO full flag.
REQ-012 SHALL have port wr_ack, input, 1, FIFO write acknowledge, one cycle after an accepted write.
REQ-013 SHALL have port overflow, input, 1, FIFO overflow flag.
REQ-014 SHALL have port gnt_id, output, $clog2(NUM_REQ), index of the current grantee.
REQ-015 SHALL have port busy, output, 1, high while in state BURST.
REQ-016 SHALL have port ovf_err, output, 1, sticky flag set on any overflow.

Function
REQ-017 SHALL implement FSM states IDLE and BURST.
REQ-018 In IDLE with any req_valid high, SHALL select the first valid requester searching round-robin from last_gnt+1 (wrapping modulo NUM_REQ), register it into gnt_id and last_gnt, clear beat_cnt, and enter BURST next cycle (one-cycle arbitration bubble).
REQ-019 In IDLE, wr_en and req_ready SHALL be 0.
REQ-020 In BURST, wr_en SHALL equal req_valid[gnt_id] & ~full, combinationally.
REQ-021 req_ready[i] SHALL equal wr_en & (i == gnt_id); all other bits SHALL be 0.
REQ-022 data_in SHALL equal req_data slice gnt_id whenever state is BURST; in IDLE it SHALL hold 0.
REQ-023 Each cycle with wr_en=1 SHALL increment beat_cnt.
REQ-024 SHALL return to IDLE when a beat is accepted with beat_cnt == BURST_MAX-1.
REQ-025 SHALL return to IDLE when req_valid[gnt_id] is 0 in BURST; no beat is written that cycle.
REQ-026 full=1 with req_valid[gnt_id]=1 SHALL stall: remain in BURST, beat_cnt unchanged, grant held.
REQ-027 Lower-index requesters SHALL NOT starve: after a grant to requester k, requester k has lowest priority at the next arbitration.
REQ-028 overflow=1 on any cycle SHALL set ovf_err on the next edge; ovf_err SHALL clear only on reset.
REQ-029 wr_ack SHALL be used only by the statistics feature; the arbiter never waits on it.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, last_gnt=NUM_REQ-1 (requester 0 wins first), gnt_id=0, beat_cnt=0, ovf_err=0, busy=0; wr_en, req_ready and data_in SHALL be 0 in the following cycle.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no further write; no partial state SHALL survive.

Configuration
REQ-032 With macro FIFO_WR_ARB_STATS_EN defined, SHALL add output ack_cnt, NUM_REQ*16 bits: per-requester saturating counters (at 16'hFFFF) incremented when wr_ack=1, credited to the requester that was written the previous cycle (registered owner), and cleared by reset.
REQ-033 Without FIFO_WR_ARB_STATS_EN, port ack_cnt and its logic SHALL be absent, and wr_ack SHALL be unused.

Structure
REQ-034 A shared package fifo_arb_pkg SHALL hold the FSM state typedef (arb_state_t: ARB_IDLE, ARB_BURST) and the default constants NUM_REQ, FIFO_WIDTH and BURST_MAX.
REQ-035 The round-robin selector SHALL be a sub-module rr_pick: inputs valid vector and last grant; outputs pick index and any-valid.

Verification
REQ-036 Reset: all req_valid=1 during reset; release -> IDLE for 1 cycle, gnt_id=0, then 4 beats of requester 0 on wr_en, then requester 1 granted.
REQ-037 Round-robin: NUM_REQ=4, all valid continuously, full=0 -> grant order 0,1,2,3,0, each 4 beats and 1 bubble cycle; 16 writes in 20 cycles.
REQ-038 Early release: requester 2 alone, valid for 2 beats then 0 -> 2 writes, return to IDLE, busy=0, beat_cnt not carried over.
REQ-039 Backpressure: full=1 for 3 cycles at beat 2 of requester 1 -> wr_en=0 and req_ready=0 for those cycles, grant held, burst completes with exactly 4 writes.
REQ-040 Overflow/reset: pulse overflow once -> ovf_err=1 next cycle and stays; assert rst mid-burst -> wr_en=0 next cycle, ovf_err=0, requester 0 wins next.
REQ-041 Stats (FIFO_WR_ARB_STATS_EN): 5 acked writes from requester 3 -> ack_cnt slice 3 = 5, other slices = 0; preload to 16'hFFFE, 3 acks -> 16'hFFFF.
